// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared encodings for the burst shift register
package shift_reg_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SHR  = 3'b001,
        SHL  = 3'b010,
        LOAD = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational next-value function of the shift register
module shift_core
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_e            mode_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             serial_in_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] q_next_o
);

    logic [WIDTH-1:0]   ones;
    logic [WIDTH-1:0]   hi_fill_mask;
    logic [WIDTH-1:0]   lo_fill_mask;
    logic [2*WIDTH-1:0] dbl_r;
    logic [2*WIDTH-1:0] dbl_l;

    // Fill masks mark the vacated bit positions; rotates use a doubled copy of q
    always_comb begin
        ones         = '1;
        hi_fill_mask = ~(ones >> amt_i);
        lo_fill_mask = ~(ones << amt_i);
        dbl_r        = {q_i, q_i} >> amt_i;
        dbl_l        = {q_i, q_i} << amt_i;
        q_next_o     = q_i;
        unique case (mode_i)
            HOLD: q_next_o = q_i;
            SHR:  q_next_o = (q_i >> amt_i) | (serial_in_i ? hi_fill_mask : '0);
            SHL:  q_next_o = (q_i << amt_i) | (serial_in_i ? lo_fill_mask : '0);
            LOAD: q_next_o = in_i;
            ROR:  q_next_o = dbl_r[WIDTH-1:0];
            ROL:  q_next_o = dbl_l[2*WIDTH-1:WIDTH];
            ASR:  q_next_o = (q_i >> amt_i) | (q_i[WIDTH-1] ? hi_fill_mask : '0);
            CLR:  q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/burst_shift_register.sv
// rtl/burst_shift_register.sv - universal shift register with burst repeat FSM
module burst_shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = WIDTH,
    parameter int AW        = $clog2(WIDTH),
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             serial_in_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             start_i,
    input  logic [CW-1:0]    burst_len_i,
    output logic [WIDTH-1:0] q_o,
    output logic             serial_out_msb_o,
    output logic             serial_out_lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    mode_e            mode_lat_q, mode_lat_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    mode_e            core_mode;
    logic [AW-1:0]    core_amt;
    logic [WIDTH-1:0] core_next;

    // A running burst replays the latched op one position per step
    always_comb begin
        core_mode = mode_e'(mode_i);
        core_amt  = amt_i;
        if (state_q == RUN) begin
            core_mode = mode_lat_q;
            core_amt  = AW'(1);
        end
    end

    shift_core #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_core (
        .q_i         (q_q),
        .mode_i      (core_mode),
        .amt_i       (core_amt),
        .serial_in_i (serial_in_i),
        .in_i        (in_i),
        .q_next_o    (core_next)
    );

    // Next-state: direct ops or burst acceptance in IDLE, counted steps in RUN
    always_comb begin
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        count_d    = count_q;
        q_d        = q_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (burst_len_i != '0) begin
                        mode_lat_d = mode_e'(mode_i);
                        count_d    = (burst_len_i > CW'(MAX_BURST)) ? CW'(MAX_BURST) : burst_len_i;
                        state_d    = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en_i) begin
                    q_d = core_next;
                end
            end
            RUN: begin
                if (en_i) begin
                    q_d     = core_next;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and data registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mode_lat_q <= HOLD;
            count_q    <= '0;
            q_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
            count_q    <= count_d;
            q_q        <= q_d;
            done_q     <= done_d;
        end
    end

    assign q_o              = q_q;
    assign serial_out_msb_o = q_q[WIDTH-1];
    assign serial_out_lsb_o = q_q[0];
    assign busy_o           = (state_q == RUN);
    assign done_o           = done_q;

endmodule
